md_unit: RTL and testbench
==========================

Name: md_unit

Overview:
- Parametrised multiply/divide unit for the E stage of the pipelined CPU; successor to the fixed 32-bit mult/div block.
- Owns HI/LO and runs multi-cycle mult/div with configurable latency.
- Adds multiply-accumulate ops (madd/maddu/msub/msubu), defined divide-by-zero and overflow results, and a cancel path that discards an in-flight op when an interrupt or exception flushes E.
- The hazard unit stalls D-stage mult/div/mf/mt instructions while busy is high.

Parameters:
- WIDTH, 32: operand width and HI/LO width.
- MULT_CYCLES, 5: busy cycles for ops 1,2,5,6,7,8; legal range 1..255.
- DIV_CYCLES, 10: busy cycles for ops 3,4; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  launch op this cycle
- op  input  4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 madd, 6 maddu, 7 msub, 8 msubu, 9 mthi, 10 mtlo, 11-15 none
- a  input  WIDTH  rs operand
- b  input  WIDTH  rt operand
- cancel  input  1  flush E; aborts or blocks the op
- busy  output  1  op in flight
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (async, active-high): hi=0, lo=0, busy=0, counter=0, pending result cleared. Reset mid-operation aborts the op with no write.
- States: IDLE and RUN.
- Accept rule: start=1 while IDLE, cancel=0, op in 1..8.
  - Operands are captured and the result is computed into pending registers at that edge.
  - Counter loads N (MULT_CYCLES or DIV_CYCLES); state goes to RUN; busy=1 from that edge.
- RUN: counter decrements each edge. On the edge where counter goes 1 to 0:
  - {hi,lo} is written with the pending result;
  - busy falls;
  - state returns to IDLE.
- Latency: start accepted at edge k gives busy high for exactly N cycles. New hi/lo are visible after edge k+N, the same edge at which busy drops.
- mthi/mtlo (op 9/10) with start=1, IDLE, cancel=0: hi (resp. lo) is loaded with a at that edge. Single cycle; busy stays 0.
- start while RUN: ignored, no state change. The hazard unit guarantees this does not occur; the bench checks it anyway.
- cancel=1 while RUN: state goes to IDLE and busy=0 at the next edge. hi/lo keep their pre-op values.
- cancel=1 with start=1: start is ignored, including mthi/mtlo.
- cancel=1 on the completion edge: cancel wins and there is no write.
- Multiply arithmetic:
  - mult/multu produce a 2*WIDTH-bit product, signed or unsigned; {hi,lo}=product.
  - madd/maddu: {hi,lo} = {hi,lo} + product, modulo 2^(2*WIDTH).
  - msub/msubu: {hi,lo} = {hi,lo} - product, modulo 2^(2*WIDTH).
  - For accumulate ops, the hi/lo value used is the one at the accept edge.
- Divide arithmetic:
  - lo=quotient, hi=remainder.
  - Signed quotient truncates toward zero; remainder takes the dividend's sign.
  - b==0 (div and divu): lo = all ones, hi = a.
  - div with a = -2^(WIDTH-1) and b = -1: lo = -2^(WIDTH-1), hi = 0.
- hi/lo change only at a completion edge, an mthi/mtlo edge, or reset.

Test Plan:
- Reset then mult, a=0xFFFFFFFE (-2), b=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- multu, a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 cycles. Follow with maddu, a=1, b=1 -> lo=0x00000002, hi unchanged.
- div, a=-7, b=2 -> busy 10 cycles; lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Repeat with divu, b=0 -> lo=0xFFFFFFFF, hi=a. Also div, a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
- mthi a=0x12345678 then mtlo a=0x9 -> hi/lo update the edge after each start; busy never asserts.
- Cancel checks, with hi=1 and lo=2 beforehand:
  - start div, assert cancel on the 4th busy cycle -> busy=0 next edge, hi=1, lo=2.
  - cancel on the completion cycle -> no write.
  - start and cancel together -> no busy.
- Async reset asserted mid-mult, between clock edges -> busy, hi, lo go to 0 immediately.
- Parameter sweep MULT_CYCLES=1, DIV_CYCLES=1, WIDTH=16 -> busy for one cycle; mult 0x8000 by 0x8000 (signed) -> hi=0x4000, lo=0x0000.

Source files
------------

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs multi-cycle mult/div/MAC ops
// with configurable latency, and supports mthi/mtlo plus a flush-driven cancel.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int W2 = 2 * WIDTH;
    localparam logic [7:0] MULT_N = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_N  = 8'(DIV_CYCLES);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [7:0]       r_count;
    logic [7:0]       w_nextCount;
    logic [W2-1:0]    r_pend;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    logic             w_accept;
    logic             w_complete;
    logic             w_mthi;
    logic             w_mtlo;
    logic [W2-1:0]    w_result;
    logic [W2-1:0]    w_acc;
    logic [W2-1:0]    w_prodS;
    logic [W2-1:0]    w_prodU;
    logic             w_negA;
    logic             w_negB;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;
    logic [WIDTH-1:0] w_magQ;
    logic [WIDTH-1:0] w_magR;
    logic [WIDTH-1:0] w_sQuot;
    logic [WIDTH-1:0] w_sRem;
    logic [WIDTH-1:0] w_uQuot;
    logic [WIDTH-1:0] w_uRem;
    logic             w_bZero;

    assign w_acc   = {r_hi, r_lo};
    assign w_prodS = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    assign w_prodU = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    // Signed divide works on magnitudes, so the most-negative dividend over -1
    // wraps back to itself without a dedicated overflow path.
    assign w_bZero = (b == '0);
    assign w_negA  = a[WIDTH-1];
    assign w_negB  = b[WIDTH-1];
    assign w_absA  = w_negA ? -a : a;
    assign w_absB  = w_negB ? -b : b;
    assign w_magQ  = w_bZero ? '0 : w_absA / w_absB;
    assign w_magR  = w_bZero ? '0 : w_absA % w_absB;
    assign w_sQuot = (w_negA ^ w_negB) ? -w_magQ : w_magQ;
    assign w_sRem  = w_negA ? -w_magR : w_magR;
    assign w_uQuot = w_bZero ? '0 : a / b;
    assign w_uRem  = w_bZero ? '0 : a % b;

    always_comb begin
        w_result = w_acc;
        case (op)
            4'd1:    w_result = w_prodS;
            4'd2:    w_result = w_prodU;
            4'd3:    w_result = w_bZero ? {a, {WIDTH{1'b1}}} : {w_sRem, w_sQuot};
            4'd4:    w_result = w_bZero ? {a, {WIDTH{1'b1}}} : {w_uRem, w_uQuot};
            4'd5:    w_result = w_acc + w_prodS;
            4'd6:    w_result = w_acc + w_prodU;
            4'd7:    w_result = w_acc - w_prodS;
            4'd8:    w_result = w_acc - w_prodU;
            default: w_result = w_acc;
        endcase
    end

    // Cancel beats both a new start and the completion write.
    always_comb begin
        w_nextState = r_state;
        w_nextCount = r_count;
        w_accept    = 1'b0;
        w_complete  = 1'b0;
        w_mthi      = 1'b0;
        w_mtlo      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start && !cancel) begin
                    if (op >= 4'd1 && op <= 4'd8) begin
                        w_accept    = 1'b1;
                        w_nextState = RUN;
                        w_nextCount = (op == 4'd3 || op == 4'd4) ? DIV_N : MULT_N;
                    end else if (op == 4'd9) begin
                        w_mthi = 1'b1;
                    end else if (op == 4'd10) begin
                        w_mtlo = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cancel) begin
                    w_nextState = IDLE;
                    w_nextCount = '0;
                end else begin
                    w_nextCount = r_count - 8'd1;
                    if (r_count == 8'd1) begin
                        w_complete  = 1'b1;
                        w_nextState = IDLE;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
            r_pend  <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_nextState;
            r_count <= w_nextCount;
            if (w_accept) begin
                r_pend <= w_result;
            end
            if (w_complete) begin
                {r_hi, r_lo} <= r_pend;
            end else if (w_mthi) begin
                r_hi <= a;
            end else if (w_mtlo) begin
                r_lo <= a;
            end
        end
    end

    assign busy = (r_state == RUN);
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: directed and random ops compared against a plain-arithmetic
// HI/LO model, plus a 16-bit single-cycle instance for the parameter sweep.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        cancel;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    logic        s16Start;
    logic [3:0]  s16Op;
    logic [15:0] s16A;
    logic [15:0] s16B;
    logic        s16Cancel;
    logic        s16Busy;
    logic [15:0] s16Hi;
    logic [15:0] s16Lo;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    logic [31:0] mHi;
    logic [31:0] mLo;

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo)
    );

    md_unit #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut16 (
        .clk(clk), .reset(reset), .start(s16Start), .op(s16Op), .a(s16A), .b(s16B),
        .cancel(s16Cancel), .busy(s16Busy), .hi(s16Hi), .lo(s16Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result as {hi,lo}, computed with 64-bit integer arithmetic.
    function automatic logic [63:0] refResult(input int opc, input logic [31:0] ra,
                                              input logic [31:0] rb, input logic [63:0] acc);
        longint      sa;
        longint      sb;
        logic [63:0] ps;
        logic [63:0] pu;
        logic [63:0] q;
        logic [63:0] r;
        sa = longint'($signed(ra));
        sb = longint'($signed(rb));
        ps = sa * sb;
        pu = {32'b0, ra} * {32'b0, rb};
        case (opc)
            1: return ps;
            2: return pu;
            3: begin
                if (rb == 0) return {ra, 32'hFFFFFFFF};
                q = sa / sb;
                r = sa % sb;
                return {r[31:0], q[31:0]};
            end
            4: begin
                if (rb == 0) return {ra, 32'hFFFFFFFF};
                return {ra % rb, ra / rb};
            end
            5: return acc + ps;
            6: return acc + pu;
            7: return acc - ps;
            8: return acc - pu;
            default: return acc;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic [3:0] opc, input logic [31:0] ra,
                                 input logic [31:0] rb, input logic can);
        @(negedge clk);
        start  = st;
        op     = opc;
        a      = ra;
        b      = rb;
        cancel = can;
    endtask

    // Launches one op, checks HI/LO hold while busy, the busy length and the result.
    task automatic runOp(input string tag, input logic [3:0] opc, input logic [31:0] ra,
                         input logic [31:0] rb, input int n);
        logic [63:0] expect64;
        int          cycles;
        expect64 = refResult(int'(opc), ra, rb, {mHi, mLo});
        applyStimulus(1'b1, opc, ra, rb, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput({tag, "_hold"}, {hi, lo}, {mHi, mLo});
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin
            cycles++;
            @(negedge clk);
        end
        checkOutput({tag, "_cycles"}, 64'(cycles), 64'(n));
        {mHi, mLo} = expect64;
        checkOutput({tag, "_hi"}, 64'(hi), 64'(mHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(mLo));
    endtask

    task automatic doMove(input string tag, input logic [3:0] opc, input logic [31:0] ra);
        applyStimulus(1'b1, opc, ra, 32'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
        if (opc == 4'd9) mHi = ra;
        else mLo = ra;
        checkOutput({tag, "_hi"}, 64'(hi), 64'(mHi));
        checkOutput({tag, "_lo"}, 64'(lo), 64'(mLo));
    endtask

    initial begin
        int          cycles;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset = 1'b1;
        start = 1'b0; op = 4'd0; a = '0; b = '0; cancel = 1'b0;
        s16Start = 1'b0; s16Op = 4'd0; s16A = '0; s16B = '0; s16Cancel = 1'b0;
        mHi = '0;
        mLo = '0;

        @(negedge clk);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_hi", 64'(hi), 64'd0);
        checkOutput("rst_lo", 64'(lo), 64'd0);
        checkOutput("rst16_busy", 64'(s16Busy), 64'd0);
        reset = 1'b0;

        runOp("mult_neg", 4'd1, 32'hFFFFFFFE, 32'd3, 5);
        checkOutput("mult_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        runOp("multu_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5);
        checkOutput("multu_max_const", {hi, lo}, 64'hFFFFFFFE_00000001);
        runOp("maddu_1", 4'd6, 32'd1, 32'd1, 5);
        checkOutput("maddu_1_const", {hi, lo}, 64'hFFFFFFFE_00000002);

        runOp("div_neg", 4'd3, 32'hFFFFFFF9, 32'd2, 10);
        checkOutput("div_neg_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        runOp("divu_zero", 4'd4, 32'h1234ABCD, 32'd0, 10);
        checkOutput("divu_zero_const", {hi, lo}, 64'h1234ABCD_FFFFFFFF);
        runOp("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 10);
        checkOutput("div_ovf_const", {hi, lo}, 64'h00000000_80000000);

        doMove("mthi", 4'd9, 32'h12345678);
        doMove("mtlo", 4'd10, 32'h00000009);
        checkOutput("mv_const", {hi, lo}, 64'h12345678_00000009);

        // A second start while running must not disturb the mult in flight.
        applyStimulus(1'b1, 4'd1, 32'd3, 32'd3, 1'b0);
        applyStimulus(1'b1, 4'd3, 32'd100, 32'd7, 1'b0);
        cycles = 0;
        while (busy === 1'b1 && cycles < 400) begin
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        checkOutput("startrun_cycles", 64'(cycles), 64'd5);
        checkOutput("startrun_result", {hi, lo}, 64'h00000000_00000009);
        mHi = 32'd0;
        mLo = 32'd9;

        doMove("set_hi", 4'd9, 32'd1);
        doMove("set_lo", 4'd10, 32'd2);

        applyStimulus(1'b1, 4'd3, 32'd50, 32'd7, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("cmid_busy_before", 64'(busy), 64'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cmid_busy", 64'(busy), 64'd0);
        checkOutput("cmid_hilo", {hi, lo}, 64'h00000001_00000002);

        applyStimulus(1'b1, 4'd3, 32'd50, 32'd7, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (8) @(negedge clk);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b1);
        checkOutput("cend_busy_before", 64'(busy), 64'd1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cend_busy", 64'(busy), 64'd0);
        checkOutput("cend_hilo", {hi, lo}, 64'h00000001_00000002);

        applyStimulus(1'b1, 4'd1, 32'd5, 32'd5, 1'b1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("cstart_busy", 64'(busy), 64'd0);
        applyStimulus(1'b1, 4'd9, 32'hDEAD, 32'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("cstart_busy_late", 64'(busy), 64'd0);
        checkOutput("cstart_hilo", {hi, lo}, 64'h00000001_00000002);

        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(1, 10));
            ra  = $urandom;
            rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if (rop <= 4'd8) runOp($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb,
                                   (rop == 4'd3 || rop == 4'd4) ? 10 : 5);
            else doMove($sformatf("rnd%0d_op%0d", i, rop), rop, ra);
        end

        // Reset lands between edges while a mult is in flight.
        doMove("pre_rst_hi", 4'd9, 32'hA5A5A5A5);
        applyStimulus(1'b1, 4'd1, 32'd5, 32'd7, 1'b0);
        applyStimulus(1'b0, 4'd0, 32'd0, 32'd0, 1'b0);
        checkOutput("arst_busy_before", 64'(busy), 64'd1);
        #2 reset = 1'b1;
        #1;
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        mHi = '0;
        mLo = '0;
        repeat (6) @(negedge clk);
        checkOutput("arst_nowrite", {hi, lo}, 64'd0);

        @(negedge clk);
        s16Start = 1'b1; s16Op = 4'd1; s16A = 16'h8000; s16B = 16'h8000;
        @(negedge clk);
        s16Start = 1'b0;
        checkOutput("w16_mult_busy", 64'(s16Busy), 64'd1);
        @(negedge clk);
        checkOutput("w16_mult_busy_end", 64'(s16Busy), 64'd0);
        checkOutput("w16_mult_hilo", {s16Hi, s16Lo}, 64'h4000_0000);
        s16Start = 1'b1; s16Op = 4'd3; s16A = 16'hFFF9; s16B = 16'h0002;
        @(negedge clk);
        s16Start = 1'b0;
        checkOutput("w16_div_busy", 64'(s16Busy), 64'd1);
        @(negedge clk);
        checkOutput("w16_div_busy_end", 64'(s16Busy), 64'd0);
        checkOutput("w16_div_hilo", {s16Hi, s16Lo}, 64'hFFFF_FFFD);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
